shift_div_ctrl: RTL and testbench
=================================

Name: shift_div_ctrl

Overview:
Controller that sequences the 16-bit circular shift register (circ_shift_reg_16bits) used as a programmable clock divider. It accepts divide-ratio requests from a requester and generates the register's load strobe and 16-bit load pattern. It reloads only on a pattern boundary, so the divided output never glitches or produces a runt pulse. It sits between the requester (CPU/config FSM) and the shift register. Its outputs connect directly to the register's load and load_in ports, and both blocks share one clock.

Parameters:
WIDTH, 16, shift register length; fixed at 16. It is a parameter only for pattern and phase sizing.
INIT_SEL, 0, selection code loaded after reset (0 = off).

Ports:
clock  in  1  system clock; all state updates on rising edge.
reset_n  in  1  asynchronous, active-low reset.
req  in  1  request; a rising edge (0->1 between consecutive samples) starts a transaction. The requester holds sel stable until ack.
sel  in  3  requested ratio: 0 = off, 1 = div2, 2 = div4, 3 = div8, 4 = div16; 5-7 invalid.
ack  out  1  one-cycle pulse when the request completes.
err  out  1  one-cycle pulse coincident with ack for an invalid sel.
busy  out  1  high from request acceptance until the cycle after ack.
sr_load  out  1  drives the shift register's load input.
sr_load_in  out  16  drives the shift register's load_in input.
cur_sel  out  3  ratio currently running.
phase  out  4  rotations since the last load, modulo 16.

Behaviour:
- Pattern map: off = 0x0000, div2 = 0xAAAA, div4 = 0xCCCC, div8 = 0xF0F0, div16 = 0xFF00.
- The shift register loads when load=1 and rotates otherwise. All listed patterns are periodic in 16, so output frequency does not depend on rotation direction.
- Reset (asynchronous, while reset_n=0): state=INIT, sr_load=0, sr_load_in=0, ack=0, err=0, busy=0, cur_sel=0, phase=0, pending cleared. Reset mid-transaction drops the pending request with no ack.
- All outputs are registered.
- INIT: the first cycle after reset release drives sr_load=1 and sr_load_in=pattern(INIT_SEL). Then cur_sel<=INIT_SEL, phase<=0, go to RUN.
- RUN: phase increments by 1 each cycle and wraps 15->0. sr_load=0.
- A req rising edge detected in RUN is accepted; pend_sel<=sel and busy<=1. Handling depends on the case:
  - Invalid sel (5-7): the next cycle gives ack=1, err=1 and busy drops. No load, cur_sel unchanged.
  - sel==cur_sel: the next cycle gives ack=1. No load.
  - cur_sel==0 (output idle): go to LOAD immediately.
  - Otherwise: go to WAIT.
- WAIT: stay until phase==14, then go to LOAD. sr_load is therefore high during the cycle in which phase==15, and the load replaces the 16th rotation, giving a seamless boundary.
  - A request accepted while phase==14 goes to LOAD directly.
  - A request accepted while phase==15 waits a full period (boundary already missed).
- LOAD (one cycle): sr_load=1, sr_load_in=pattern(pend_sel). At the end of the cycle: cur_sel<=pend_sel, phase<=0, ack=1 next cycle, then busy<=0 and return to RUN.
- Req edges are ignored while busy=1 (no queueing, no err).
- Req held high after ack does not retrigger; a new request needs req to go low and then high again.
- Latency:
  - Immediate load from off: 2 cycles from req sample to ack.
  - No-op or invalid request: 1 cycle.
  - Load from a running ratio: up to 17 cycles.
- sr_load_in holds its last driven pattern when sr_load=0.

Decomposition:
- Shared package shift_div_pkg holds:
  - sel code constants (SEL_OFF, SEL_DIV2, SEL_DIV4, SEL_DIV8, SEL_DIV16);
  - pattern constants (PAT_OFF=0x0000, PAT_DIV2=0xAAAA, PAT_DIV4=0xCCCC, PAT_DIV8=0xF0F0, PAT_DIV16=0xFF00);
  - FSM state encoding (INIT, RUN, WAIT, LOAD, RESP).
- One combinational sub-module, div_pattern_lut (sel -> 16-bit pattern plus valid flag), shared by the controller and the bench's reference model.
- The shift register itself stays external.

Test Plan:
- Reset release with INIT_SEL=0 -> exactly one sr_load pulse carrying 0x0000; cur_sel=0; shift_out stays 0 for 100 cycles.
- From off, req with sel=3 -> ack 2 cycles after the req sample, err=0; shift_out period 8 clocks at 50% duty (4 high, 4 low); cur_sel=3.
- Running div8, req sel=1 with phase=3 -> busy high, sr_load pulse only in the cycle with phase==15, then ack. shift_out shows no high or low segment shorter than 1 clock or longer than 4; afterwards it toggles every clock.
- Req sel=6 -> ack=1 and err=1 in the same single cycle; no sr_load; cur_sel and the shift_out waveform unchanged.
- Req sel equal to cur_sel -> ack after 1 cycle with no sr_load. Req held high 20 cycles after ack -> no second ack.
- reset_n asserted during WAIT -> all outputs go to reset values immediately (before the next edge); no ack. After release, the INIT load with 0x0000 occurs.

Source files
------------

// File: rtl/shift_div_pkg.sv
// Shared definitions for the clock-divider controller: select codes, load
// patterns for the 16-bit circular shift register and controller states.
package shift_div_pkg;

    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_OFF   = 3'd0;
    localparam logic [SEL_W-1:0] SEL_DIV2  = 3'd1;
    localparam logic [SEL_W-1:0] SEL_DIV4  = 3'd2;
    localparam logic [SEL_W-1:0] SEL_DIV8  = 3'd3;
    localparam logic [SEL_W-1:0] SEL_DIV16 = 3'd4;

    localparam logic [15:0] PAT_OFF   = 16'h0000;
    localparam logic [15:0] PAT_DIV2  = 16'hAAAA;
    localparam logic [15:0] PAT_DIV4  = 16'hCCCC;
    localparam logic [15:0] PAT_DIV8  = 16'hF0F0;
    localparam logic [15:0] PAT_DIV16 = 16'hFF00;

    typedef enum logic [2:0] {
        INIT,
        RUN,
        WAIT,
        LOAD,
        RESP
    } state_e;

    function automatic logic selIsValid(input logic [SEL_W-1:0] s);
        return (s <= SEL_DIV16);
    endfunction

endpackage

// File: rtl/div_pattern_lut.sv
// Maps a divide-ratio select code to the shift-register pattern that
// produces that ratio; invalid codes yield an all-zero pattern.
module div_pattern_lut
    import shift_div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [SEL_W-1:0] sel_i,
    output logic [WIDTH-1:0] pattern_o,
    output logic             valid_o
);

    always_comb begin
        pattern_o = WIDTH'(PAT_OFF);
        valid_o   = selIsValid(sel_i);
        case (sel_i)
            SEL_OFF:   pattern_o = WIDTH'(PAT_OFF);
            SEL_DIV2:  pattern_o = WIDTH'(PAT_DIV2);
            SEL_DIV4:  pattern_o = WIDTH'(PAT_DIV4);
            SEL_DIV8:  pattern_o = WIDTH'(PAT_DIV8);
            SEL_DIV16: pattern_o = WIDTH'(PAT_DIV16);
            default:   pattern_o = WIDTH'(PAT_OFF);
        endcase
    end

endmodule

// File: rtl/shift_div_ctrl.sv
// Sequences reloads of the external 16-bit circular shift register used as a
// clock divider, switching ratios only on a full-pattern boundary.
module shift_div_ctrl
    import shift_div_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [SEL_W-1:0] INIT_SEL = 3'd0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req,
    input  logic [SEL_W-1:0]         sel,
    output logic                     ack,
    output logic                     err,
    output logic                     busy,
    output logic                     sr_load,
    output logic [WIDTH-1:0]         sr_load_in,
    output logic [SEL_W-1:0]         cur_sel,
    output logic [$clog2(WIDTH)-1:0] phase
);

    localparam int PH_W = $clog2(WIDTH);
    localparam logic [PH_W-1:0] PHASE_PRE = PH_W'(WIDTH - 2);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  pendSel_q, pendSel_d;
    logic [SEL_W-1:0]  curSel_q, curSel_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              initLoad_q, initLoad_d;
    logic              reqPrev_q;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              srLoad_q, srLoad_d;
    logic [WIDTH-1:0]  srLoadIn_q, srLoadIn_d;

    logic [SEL_W-1:0]  lutSel;
    logic [WIDTH-1:0]  lutPattern;
    logic              lutValid;
    logic              reqEdge;

    // A fresh request is looked up directly; a deferred one uses the captured code.
    always_comb begin
        lutSel = pendSel_q;
        if (state_q == INIT) begin
            lutSel = INIT_SEL;
        end else if (state_q == RUN) begin
            lutSel = sel;
        end
    end

    div_pattern_lut #(
        .WIDTH(WIDTH)
    ) u_lut (
        .sel_i    (lutSel),
        .pattern_o(lutPattern),
        .valid_o  (lutValid)
    );

    assign reqEdge = req & ~reqPrev_q;

    always_comb begin
        state_d    = state_q;
        pendSel_d  = pendSel_q;
        curSel_d   = curSel_q;
        phase_d    = phase_q + 1'b1;
        initLoad_d = initLoad_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        busy_d     = busy_q;
        srLoad_d   = 1'b0;
        srLoadIn_d = srLoadIn_q;

        case (state_q)
            INIT: begin
                phase_d    = '0;
                pendSel_d  = INIT_SEL;
                initLoad_d = 1'b1;
                srLoad_d   = 1'b1;
                srLoadIn_d = lutPattern;
                state_d    = LOAD;
            end
            RUN: begin
                if (reqEdge) begin
                    pendSel_d = sel;
                    busy_d    = 1'b1;
                    if (!lutValid) begin
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (sel == curSel_q) begin
                        ack_d   = 1'b1;
                        state_d = RESP;
                    end else if (curSel_q == SEL_OFF || phase_q == PHASE_PRE) begin
                        srLoad_d   = 1'b1;
                        srLoadIn_d = lutPattern;
                        state_d    = LOAD;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            // Loading in the phase-15 cycle replaces the 16th rotation exactly.
            WAIT: begin
                if (phase_q == PHASE_PRE) begin
                    srLoad_d   = 1'b1;
                    srLoadIn_d = lutPattern;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                curSel_d   = pendSel_q;
                phase_d    = '0;
                initLoad_d = 1'b0;
                ack_d      = ~initLoad_q;
                state_d    = initLoad_q ? RUN : RESP;
            end
            RESP: begin
                busy_d  = 1'b0;
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= INIT;
            pendSel_q  <= SEL_OFF;
            curSel_q   <= SEL_OFF;
            phase_q    <= '0;
            initLoad_q <= 1'b0;
            reqPrev_q  <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            srLoad_q   <= 1'b0;
            srLoadIn_q <= '0;
        end else begin
            state_q    <= state_d;
            pendSel_q  <= pendSel_d;
            curSel_q   <= curSel_d;
            phase_q    <= phase_d;
            initLoad_q <= initLoad_d;
            reqPrev_q  <= req;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            srLoad_q   <= srLoad_d;
            srLoadIn_q <= srLoadIn_d;
        end
    end

    assign ack        = ack_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign sr_load    = srLoad_q;
    assign sr_load_in = srLoadIn_q;
    assign cur_sel    = curSel_q;
    assign phase      = phase_q;

endmodule

// File: tb/tb_shift_div_ctrl.sv
// Self-checking bench for shift_div_ctrl: models the external shift register
// and predicts ack latency, loads and resulting ratio from the request rules.
module tb_shift_div_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req;
    logic [2:0]  sel;
    logic        ack;
    logic        err;
    logic        busy;
    logic        sr_load;
    logic [15:0] sr_load_in;
    logic [2:0]  cur_sel;
    logic [3:0]  phase;

    int          checks;
    int          errors;
    logic [15:0] srModel;
    int          modelPhase;
    int          curModel;
    int          runLen;
    int          maxRun;
    int          highCount;
    logic        lastOut;
    int          ackCount;
    int          loadCount;

    always #5 clock = ~clock;

    shift_div_ctrl dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .sel       (sel),
        .ack       (ack),
        .err       (err),
        .busy      (busy),
        .sr_load   (sr_load),
        .sr_load_in(sr_load_in),
        .cur_sel   (cur_sel),
        .phase     (phase)
    );

    function automatic logic [15:0] expectedPattern(input int s);
        case (s)
            1:       return 16'hAAAA;
            2:       return 16'hCCCC;
            3:       return 16'hF0F0;
            4:       return 16'hFF00;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One clock; updates the shift-register model and waveform statistics.
    task automatic tick();
        logic        prevLoad;
        logic [15:0] prevIn;
        prevLoad = sr_load;
        prevIn   = sr_load_in;
        @(posedge clock);
        #1;
        if (prevLoad === 1'b1) begin
            srModel    = prevIn;
            modelPhase = 0;
        end else begin
            srModel    = {srModel[14:0], srModel[15]};
            modelPhase = (modelPhase + 1) % 16;
        end
        if (runLen == 0 || srModel[15] !== lastOut) runLen = 1;
        else runLen++;
        lastOut = srModel[15];
        if (runLen > maxRun) maxRun = runLen;
        if (srModel[15] === 1'b1) highCount++;
        if (ack === 1'b1) ackCount++;
        if (sr_load === 1'b1) loadCount++;
    endtask

    task automatic clearRuns();
        runLen    = 0;
        maxRun    = 0;
        highCount = 0;
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_sr_load"}, sr_load, 0);
        checkOutput({pfx, "_sr_load_in"}, sr_load_in, 0);
        checkOutput({pfx, "_ack"}, ack, 0);
        checkOutput({pfx, "_err"}, err, 0);
        checkOutput({pfx, "_busy"}, busy, 0);
        checkOutput({pfx, "_cur_sel"}, cur_sel, 0);
        checkOutput({pfx, "_phase"}, phase, 0);
    endtask

    task automatic waitPhase(input int target);
        int n;
        n = 0;
        while (int'(phase) != target && n < 40) begin
            tick();
            n++;
        end
        checkOutput("wait_phase", phase, target);
    endtask

    // Issues one request and checks latency, err, load and resulting ratio.
    task automatic applyStimulus(input int s, input int holdTicks, input bit poke);
        int          p, expLat, expLoads, expErr, expCur, k;
        int          ackAt, loads, loadPh, acks0, t;
        logic [15:0] loadPat;
        logic        errAtAck;
        p = int'(phase);
        expErr = 0;
        expLoads = 0;
        expCur = curModel;
        if (s > 4) begin
            expLat = 1;
            expErr = 1;
        end else if (s == curModel) begin
            expLat = 1;
        end else if (curModel == 0) begin
            expLat = 2;
            expLoads = 1;
            expCur = s;
        end else begin
            k = (15 - p + 16) % 16;
            if (k == 0) k = 16;
            expLat = k + 1;
            expLoads = 1;
            expCur = s;
        end
        ackAt = 0;
        loads = 0;
        loadPh = -1;
        loadPat = 16'h0;
        errAtAck = 1'b0;
        acks0 = ackCount;
        sel = 3'(s);
        req = 1'b1;
        t = 0;
        while (ackAt == 0 && t < 20) begin
            tick();
            t++;
            if (t == 1) checkOutput("busy_on_accept", busy, 1);
            if (sr_load === 1'b1) begin
                loads++;
                loadPh = int'(phase);
                loadPat = sr_load_in;
            end
            if (ack === 1'b1) begin
                ackAt = t;
                errAtAck = err;
            end
            if (poke && expLat > 6 && t == 3) req = 1'b0;
            if (poke && expLat > 6 && t == 4) req = 1'b1;
        end
        if (holdTicks == 0) req = 1'b0;
        tick();
        checkOutput("ack_latency", ackAt, expLat);
        checkOutput("err_at_ack", errAtAck, expErr);
        checkOutput("ack_single", ack, 0);
        checkOutput("busy_after_ack", busy, 0);
        checkOutput("load_count", loads, expLoads);
        checkOutput("ack_count", ackCount - acks0, 1);
        checkOutput("cur_sel", cur_sel, expCur);
        checkOutput("phase_track", phase, modelPhase);
        if (expLoads == 1) begin
            checkOutput("load_pattern", loadPat, expectedPattern(s));
            if (curModel != 0) checkOutput("load_phase", loadPh, 15);
        end
        if (holdTicks > 0) begin
            acks0 = ackCount;
            repeat (holdTicks) tick();
            checkOutput("hold_no_retrigger", ackCount - acks0, 0);
            req = 1'b0;
            tick();
        end
        curModel = expCur;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int loads0, acks0, target, s;
        checks = 0;
        errors = 0;
        srModel = 16'h0;
        modelPhase = 0;
        curModel = 0;
        lastOut = 1'b0;
        ackCount = 0;
        loadCount = 0;
        clearRuns();
        reset_n = 1'b0;
        req = 1'b0;
        sel = 3'd0;

        $display("[TB] reset and INIT load");
        repeat (3) tick();
        checkResetValues("reset");
        reset_n = 1'b1;
        tick();
        checkOutput("init_load", sr_load, 1);
        checkOutput("init_pattern", sr_load_in, 16'h0000);
        tick();
        checkOutput("init_load_end", sr_load, 0);
        loads0 = loadCount;
        clearRuns();
        repeat (100) tick();
        checkOutput("off_no_loads", loadCount - loads0, 0);
        checkOutput("off_output_low", highCount, 0);
        checkOutput("off_cur_sel", cur_sel, 0);

        $display("[TB] off -> div8");
        applyStimulus(3, 0, 0);
        clearRuns();
        repeat (16) tick();
        checkOutput("div8_high_count", highCount, 8);
        checkOutput("div8_max_run", maxRun, 4);

        $display("[TB] div8 -> div2 from phase 3");
        waitPhase(3);
        clearRuns();
        applyStimulus(1, 0, 0);
        checkOutput("transition_run_le4", maxRun <= 4, 1);
        clearRuns();
        repeat (16) tick();
        checkOutput("div2_toggle", maxRun, 1);

        $display("[TB] invalid select");
        loads0 = loadCount;
        applyStimulus(6, 0, 0);
        checkOutput("invalid_no_load", loadCount - loads0, 0);
        clearRuns();
        repeat (16) tick();
        checkOutput("invalid_wave_same", maxRun, 1);

        $display("[TB] same select, req held high");
        applyStimulus(1, 20, 0);

        $display("[TB] randomized requests");
        for (int i = 0; i < 8; i++) begin
            s = int'($urandom_range(0, 7));
            repeat ($urandom_range(0, 20)) tick();
            applyStimulus(s, 0, 1);
        end

        $display("[TB] reset during WAIT");
        if (curModel == 0) applyStimulus(2, 0, 0);
        target = (curModel == 2) ? 4 : 2;
        waitPhase(2);
        sel = 3'(target);
        req = 1'b1;
        repeat (3) tick();
        checkOutput("wait_busy", busy, 1);
        checkOutput("wait_no_load", sr_load, 0);
        #2;
        reset_n = 1'b0;
        #1;
        checkResetValues("async_reset");
        req = 1'b0;
        acks0 = ackCount;
        repeat (3) tick();
        checkOutput("reset_no_ack", ackCount - acks0, 0);
        reset_n = 1'b1;
        tick();
        checkOutput("reinit_load", sr_load, 1);
        checkOutput("reinit_pattern", sr_load_in, 16'h0000);
        tick();
        curModel = 0;
        applyStimulus(4, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
